ex_controller: RTL and testbench
================================

# ex_controller

Combinational decoder for the execute (EX) stage of the multi-cycle RV32IM core, instantiated inside the main controller FSM. From the current instruction's opcode, func3 and func7 bits it produces the ALU operation, the multiply-unit (MU) operation, the EX result-mux select and a one-cycle MU start pulse. All decode outputs are valid in the same cycle the instruction fields are presented.

## Interface

Reset is asynchronous and active-high; one clock.

Parameters:
- ifuresctl_N, default 2: number of inputs on the EX result mux. Must be ≥ 2. Index 0 selects the ALU and index 1 selects the MU; other indices are unused.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  7  instruction bits [6:0].
- func3  input  3  instruction bits [14:12].
- func7b50  input  2  {func7[5], func7[0]}. Bit 1 is 1 for SUB/SRA/SRAI; bit 0 is 1 for M-extension.
- aluctl  output  4  ALU operation code.
- mulctl  output  2  MU operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- ifuresctl  output  $clog2(ifuresctl_N)  result-mux select; 0 = ALU, 1 = MU.
- mulstart  output  1  one-cycle MU start pulse.

## Operation

aluctl encoding, formed as {b5, func3}:
- 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.

Decode rules:
- **R-type ALU** (opcode 0110011, func7b50[0]=0): aluctl = {func7b50[1], func3}; ifuresctl = 0; mulctl = 00.
- **M-extension multiply** (opcode 0110011, func7b50[0]=1, func3[2]=0): mulctl = func3[1:0]; ifuresctl = 1; aluctl = 0000.
- **M-extension divide/rem** (func3[2]=1): unsupported. Outputs aluctl = 0000, ifuresctl = 0, mulctl = 00; mulstart never asserts.
- **I-type ALU** (opcode 0010011):
  - func3 = 101: aluctl = {func7b50[1], 101}.
  - All other func3: aluctl = {0, func3}. SUB is not possible; func7b50 is ignored.
  - ifuresctl = 0.
- **Branch** (opcode 1100011):
  - func3 000/001: aluctl = 1000.
  - func3 100/101: aluctl = 0010.
  - func3 110/111: aluctl = 0011.
  - func3 010/011: aluctl = 0000.
- **All other opcodes** (load, store, JAL, JALR, LUI, AUIPC, system, illegal): aluctl = 0000, ifuresctl = 0, mulctl = 00.

mulstart:
- The block holds a registered copy of {opcode, func3, func7b50} called last_key, plus a first flag.
- On each rising edge when not in reset: last_key ← current fields; first ← 0.
- mulstart = is_mul AND (first OR current fields ≠ last_key), where is_mul is the M-extension multiply case above.
- Effect: mulstart is high for exactly the first cycle a given multiply encoding is presented, then drops while the fields stay stable.
- Two consecutive instructions with identical encodings produce one pulse only. The surrounding FSM guarantees a field change between them; the IF stage presents new bits.

Reset:
- While rst=1: mulstart = 0; last_key = 0; first = 1.
- Decode outputs (aluctl, mulctl, ifuresctl) remain purely combinational from the inputs and do not depend on rst.

## Timing

- aluctl, mulctl, ifuresctl: zero-cycle combinational latency from the inputs.
- mulstart: combinational from the inputs and registered state. It rises in the same cycle a new multiply encoding appears and falls after the next rising edge.
- Asynchronous reset asserted mid-pulse forces mulstart low immediately.
- After rst deasserts, a multiply already present on the inputs pulses mulstart in the first cycle.
- Fields changing from one multiply to a different multiply: new pulse.
- Fields changing from a multiply to a non-multiply: no pulse.

## Test plan

- ADD vs SUB: opcode 0110011, func3 000, func7b50 00 → aluctl 0000, ifuresctl 0. With func7b50 10 → aluctl 1000.
- I-type: opcode 0010011, func3 101, func7b50 10 (SRAI) → aluctl 1101. Then func3 000, func7b50 10 (ADDI) → aluctl 0000.
- MULHU pulse: rst 1→0, then opcode 0110011, func3 011, func7b50 01 held 4 cycles → mulctl 11, ifuresctl 1, mulstart high in cycle 1 only.
- Multiply sequence: MUL, then MULH, then ADD, each held 2 cycles → mulstart pulses once each for MUL and MULH, none for ADD.
- Reset mid-pulse: assert rst while mulstart=1 → mulstart 0 immediately. Release with the same MUL still presented → one new pulse.
- Branch and divide:
  - BLTU (1100011, func3 110) → aluctl 0011.
  - DIV (0110011, func3 100, func7b50 01) → ifuresctl 0, mulstart 0, aluctl 0000.

Source files
------------

// File: rtl/ex_controller.sv
// EX-stage decoder: ALU/MU operation selects, result-mux select and
// a one-shot MU start pulse keyed on the instruction encoding.
module ex_controller #(
  parameter int ifuresctl_N = 2,
  localparam int W = (ifuresctl_N > 1) ? $clog2(ifuresctl_N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [6:0]   opcode,
  input  logic [2:0]   func3,
  input  logic [1:0]   func7b50,
  output logic [3:0]   aluctl,
  output logic [1:0]   mulctl,
  output logic [W-1:0] ifuresctl,
  output logic         mulstart
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  logic [11:0] key;
  logic [11:0] last_key_q, last_key_d;
  logic        first_q, first_d;
  logic        is_mul;

  assign key = {opcode, func3, func7b50};

  always_comb begin
    aluctl    = ALU_ADD;
    mulctl    = 2'b00;
    ifuresctl = '0;
    is_mul    = 1'b0;
    case (opcode)
      OP_R: begin
        if (func7b50[0]) begin
          // divide/remainder falls through with all-zero outputs
          if (!func3[2]) begin
            is_mul    = 1'b1;
            mulctl    = func3[1:0];
            ifuresctl = W'(1);
          end
        end else begin
          aluctl = {func7b50[1], func3};
        end
      end
      OP_IMM: begin
        if (func3 == 3'b101) aluctl = {func7b50[1], func3};
        else                 aluctl = {1'b0, func3};
      end
      OP_BR: begin
        case (func3[2:1])
          2'b00:   aluctl = ALU_SUB;
          2'b10:   aluctl = ALU_SLT;
          2'b11:   aluctl = ALU_SLTU;
          default: aluctl = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    last_key_d = key;
    first_d    = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_key_q <= '0;
      first_q    <= 1'b1;
    end else begin
      last_key_q <= last_key_d;
      first_q    <= first_d;
    end
  end

  assign mulstart = is_mul & ~rst & (first_q | (key != last_key_q));

endmodule

// File: tb/tb_ex_controller.sv
// Scoreboard bench for ex_controller: expected decode results are
// queued as stimulus is applied and popped when outputs are sampled.
module tb_ex_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] func3;
  logic [1:0] func7b50;
  logic [3:0] aluctl;
  logic [1:0] mulctl;
  logic [0:0] ifuresctl;
  logic       mulstart;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [3:0] alu;
    logic [1:0] mul;
    logic       res;
    logic       start;
  } exp_t;

  exp_t sb_q[$];

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] B  = 7'b1100011;
  localparam logic [6:0] LD = 7'b0000011;

  ex_controller #(.ifuresctl_N(2)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func3(func3),
    .func7b50(func7b50), .aluctl(aluctl), .mulctl(mulctl),
    .ifuresctl(ifuresctl), .mulstart(mulstart)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input string tag, input logic [6:0] op,
                       input logic [2:0] f3, input logic [1:0] f7,
                       input logic [3:0] ea, input logic [1:0] em,
                       input logic er, input logic es);
    exp_t e;
    opcode = op; func3 = f3; func7b50 = f7;
    e.tag = tag; e.alu = ea; e.mul = em; e.res = er; e.start = es;
    sb_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    chk({e.tag, ".alu"}, 32'(aluctl), 32'(e.alu));
    chk({e.tag, ".mul"}, 32'(mulctl), 32'(e.mul));
    chk({e.tag, ".res"}, 32'(ifuresctl), 32'(e.res));
    chk({e.tag, ".start"}, 32'(mulstart), 32'(e.start));
  endtask

  // one cycle: apply fields at a negedge, sample, move to next negedge
  task automatic step(input string tag, input logic [6:0] op,
                      input logic [2:0] f3, input logic [1:0] f7,
                      input logic [3:0] ea, input logic [1:0] em,
                      input logic er, input logic es);
    drive(tag, op, f3, f7, ea, em, er, es);
    sample();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; opcode = '0; func3 = '0; func7b50 = '0;
    @(negedge clk);
    step("rst_add",   R, 3'b000, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0);
    step("rst_mulhu", R, 3'b011, 2'b01, 4'b0000, 2'b11, 1'b1, 1'b0);
    rst = 1'b0;
    step("mulhu0", R, 3'b011, 2'b01, 4'b0000, 2'b11, 1'b1, 1'b1);
    for (int i = 1; i < 4; i++)
      step($sformatf("mulhu%0d", i), R, 3'b011, 2'b01,
           4'b0000, 2'b11, 1'b1, 1'b0);
    step("add",   R,  3'b000, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0);
    step("sub",   R,  3'b000, 2'b10, 4'b1000, 2'b00, 1'b0, 1'b0);
    step("sra",   R,  3'b101, 2'b10, 4'b1101, 2'b00, 1'b0, 1'b0);
    step("sltu",  R,  3'b011, 2'b00, 4'b0011, 2'b00, 1'b0, 1'b0);
    step("srai",  I,  3'b101, 2'b10, 4'b1101, 2'b00, 1'b0, 1'b0);
    step("addi",  I,  3'b000, 2'b10, 4'b0000, 2'b00, 1'b0, 1'b0);
    step("xori",  I,  3'b100, 2'b11, 4'b0100, 2'b00, 1'b0, 1'b0);
    step("bltu",  B,  3'b110, 2'b00, 4'b0011, 2'b00, 1'b0, 1'b0);
    step("beq",   B,  3'b000, 2'b00, 4'b1000, 2'b00, 1'b0, 1'b0);
    step("bge",   B,  3'b101, 2'b00, 4'b0010, 2'b00, 1'b0, 1'b0);
    step("b010",  B,  3'b010, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0);
    step("load",  LD, 3'b010, 2'b10, 4'b0000, 2'b00, 1'b0, 1'b0);
    step("div",   R,  3'b100, 2'b01, 4'b0000, 2'b00, 1'b0, 1'b0);
    step("rem",   R,  3'b110, 2'b01, 4'b0000, 2'b00, 1'b0, 1'b0);
    step("mul0",  R,  3'b000, 2'b01, 4'b0000, 2'b00, 1'b1, 1'b1);
    step("mul1",  R,  3'b000, 2'b01, 4'b0000, 2'b00, 1'b1, 1'b0);
    step("mulh0", R,  3'b001, 2'b01, 4'b0000, 2'b01, 1'b1, 1'b1);
    step("mulh1", R,  3'b001, 2'b01, 4'b0000, 2'b01, 1'b1, 1'b0);
    step("addq0", R,  3'b000, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0);
    step("addq1", R,  3'b000, 2'b00, 4'b0000, 2'b00, 1'b0, 1'b0);
    drive("mulhsu", R, 3'b010, 2'b01, 4'b0000, 2'b10, 1'b1, 1'b1);
    sample();
    rst = 1'b1;
    #1;
    chk("rst_mid.start", 32'(mulstart), 32'd0);
    chk("rst_mid.mul", 32'(mulctl), 32'd2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst0", R, 3'b010, 2'b01, 4'b0000, 2'b10, 1'b1, 1'b1);
    step("post_rst1", R, 3'b010, 2'b01, 4'b0000, 2'b10, 1'b1, 1'b0);
    step("mul_again", R, 3'b000, 2'b01, 4'b0000, 2'b00, 1'b1, 1'b1);
    step("to_and",    R, 3'b111, 2'b00, 4'b0111, 2'b00, 1'b0, 1'b0);
    if (sb_q.size() != 0) chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=1 expected=0");
    $fatal(1, "timeout");
  end

endmodule
